// File: rtl/reg_sample_fifo_if.sv
// reg_sample_fifo_if: sampling request and valid/ready output stream for reg_sample_fifo.
// The master side drives the live register value, capture requests and the
// consumer's ready. The slave side (the FIFO) returns the head sample, its delta,
// the occupancy and the sticky overflow flag.
interface reg_sample_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             sample_in;
  logic                         sample_req;
  logic                         out_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic [WIDTH-1:0]             out_delta;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         overflow;

  modport master (
    output sample_in, sample_req, out_ready,
    input  out_valid, out_data, out_delta, count, overflow
  );

  modport slave (
    input  sample_in, sample_req, out_ready,
    output out_valid, out_data, out_delta, count, overflow
  );
endinterface

// File: rtl/reg_sample_fifo.sv
// reg_sample_fifo: captures snapshots of an upstream free-running register on request
// and buffers them in a small first-word fall-through FIFO. The consumer drains the
// FIFO over a valid/ready stream. A request made while the FIFO is full and nothing
// is popping is dropped, and the sticky overflow flag is set.
// Optional feature macro: REG_SAMPLE_FIFO_DELTA_EN. When it is defined, every entry
// also stores the difference from the previously accepted sample (mod 2^WIDTH).
// When it is undefined, out_delta is tied to 0.
module reg_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  reg_sample_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  // A full FIFO still accepts a request when its head leaves in the same cycle.
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = !empty && bus.out_ready;
  assign push  = bus.sample_req && (!full || pop);

  // Pointers, occupancy and sticky overflow. Reset overrides any push or pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);
      if (bus.sample_req && !push) ovf <= 1'b1;
    end
  end

`ifdef REG_SAMPLE_FIFO_DELTA_EN
  logic [WIDTH-1:0] delta_mem [DEPTH];
  logic [WIDTH-1:0] last_sample;
  logic [WIDTH-1:0] delta_in;

  // Unsigned subtraction wraps, so a counter rolling over from all-ones to zero
  // produces a small positive delta.
  assign delta_in = bus.sample_in - last_sample;

  // Track the most recent accepted sample. Dropped requests leave it unchanged.
  always_ff @(posedge clock) begin
    if (reset)
      last_sample <= '0;
    else if (push)
      last_sample <= bus.sample_in;
  end

  // Sample and delta storage. No reset is needed because empty entries are masked.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr]       <= bus.sample_in;
      delta_mem[wr_ptr] <= delta_in;
    end
  end

  assign bus.out_delta = empty ? '0 : delta_mem[rd_ptr];
`else
  // Sample storage. No reset is needed because empty entries are masked.
  always_ff @(posedge clock) begin
    if (!reset && push)
      mem[wr_ptr] <= bus.sample_in;
  end

  assign bus.out_delta = '0;
`endif

  // The head is presented combinationally and is forced to zero when the FIFO is empty.
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr];
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_reg_sample_fifo.sv
// tb_reg_sample_fifo: directed test of reg_sample_fifo (WIDTH=8, DEPTH=4).
// Expected values are hand-computed. The delta expectations follow
// REG_SAMPLE_FIFO_DELTA_EN and are zero when that macro is undefined.
module tb_reg_sample_fifo;
  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  reg_sample_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

  reg_sample_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Delta value that is expected for a stored entry in the current build.
  function automatic logic [7:0] exp_delta(input logic [7:0] d);
`ifdef REG_SAMPLE_FIFO_DELTA_EN
    return d;
`else
    return 8'h00 & d;
`endif
  endfunction

  // Advance one rising edge, then settle 1 ns before anything is driven or sampled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic rst, input logic req, input logic [7:0] din, input logic rdy);
    reset          = rst;
    bus.sample_req = req;
    bus.sample_in  = din;
    bus.out_ready  = rdy;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Compare the full output state in a single call.
  task automatic check_state(input string tag, input logic v, input logic [7:0] d,
                             input logic [7:0] dl, input logic [2:0] c, input logic o);
    check_output({tag, ".valid"},    32'(bus.out_valid), 32'(v));
    check_output({tag, ".data"},     32'(bus.out_data),  32'(d));
    check_output({tag, ".delta"},    32'(bus.out_delta), 32'(dl));
    check_output({tag, ".count"},    32'(bus.count),     32'(c));
    check_output({tag, ".overflow"}, 32'(bus.overflow),  32'(o));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset, then idle for three cycles.
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    tick(); tick(); tick();
    check_state("reset_idle", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // Push a single entry. It becomes visible one cycle later and then pops.
    apply_stimulus(1'b0, 1'b1, 8'h10, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("single_push", 1'b1, 8'h10, exp_delta(8'h10), 3'd1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("single_pop", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // Fill the FIFO, then overflow with 0x05 while out_ready is low.
    apply_stimulus(1'b0, 1'b1, 8'h01, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h02, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h03, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h04, 1'b0); tick();
    check_state("fill4", 1'b1, 8'h01, exp_delta(8'hF1), 3'd4, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h05, 1'b0); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("overflow", 1'b1, 8'h01, exp_delta(8'hF1), 3'd4, 1'b1);

    // Drain the FIFO. The dropped 0x05 must never appear in the output.
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    check_state("drain_1", 1'b1, 8'h02, exp_delta(8'h01), 3'd3, 1'b1);
    tick();
    check_state("drain_2", 1'b1, 8'h03, exp_delta(8'h01), 3'd2, 1'b1);
    tick();
    check_state("drain_3", 1'b1, 8'h04, exp_delta(8'h01), 3'd1, 1'b1);
    tick();
    check_state("drain_empty", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    tick();
    check_state("ready_while_empty", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

    // Clear the sticky overflow flag, then push and pop together while the FIFO is full.
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h21, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h22, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h23, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h24, 1'b0); tick();
    check_state("refill", 1'b1, 8'h21, exp_delta(8'h21), 3'd4, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h09, 1'b1); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    check_state("full_push_pop", 1'b1, 8'h22, exp_delta(8'h01), 3'd4, 1'b0);
    tick();
    check_state("fpp_drain_1", 1'b1, 8'h23, exp_delta(8'h01), 3'd3, 1'b0);
    tick();
    check_state("fpp_drain_2", 1'b1, 8'h24, exp_delta(8'h01), 3'd2, 1'b0);
    tick();
    check_state("fpp_drain_3", 1'b1, 8'h09, exp_delta(8'hE5), 3'd1, 1'b0);
    tick();
    check_state("fpp_empty", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // The delta must wrap correctly across the 0xFF -> 0x00 boundary.
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'hFE, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h03, 1'b0); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("wrap_first", 1'b1, 8'hFE, exp_delta(8'hFE), 3'd2, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1); tick();
    check_state("wrap_second", 1'b1, 8'h03, exp_delta(8'h05), 3'd1, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("wrap_empty", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // Fill, overflow, then pop once to leave three entries. Assert reset together
    // with a push and a pop: reset must win.
    apply_stimulus(1'b0, 1'b1, 8'h41, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h42, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h43, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h44, 1'b0); tick();
    apply_stimulus(1'b0, 1'b1, 8'h45, 1'b0); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("pre_reset", 1'b1, 8'h42, exp_delta(8'h01), 3'd3, 1'b1);
    apply_stimulus(1'b1, 1'b1, 8'h40, 1'b1); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("reset_wins", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    // The last accepted sample must be cleared by that reset. Then push and pop
    // together while the FIFO holds one entry.
    apply_stimulus(1'b0, 1'b1, 8'h07, 1'b0); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("post_reset_push", 1'b1, 8'h07, exp_delta(8'h07), 3'd1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'h51, 1'b1); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("one_push_pop", 1'b1, 8'h51, exp_delta(8'h4A), 3'd1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1); tick();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_state("final_empty", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
